// File: rtl/jk_mode_counter.sv
// jk_mode_counter: WIDTH-bit bank of JK flip-flops with selectable operating mode.
// Modes: per-bit JK, modulo up-count, modulo down-count, parallel load with clamp.
// tc is a registered one-cycle pulse on the cycle after a wrap; zero is combinational.
module jk_mode_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    // Compares run one bit wider than q so MODULUS = 2**WIDTH is representable.
    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0]    MOD_E = EW'(MODULUS);
    localparam logic [EW-1:0]    MAX_E = EW'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [WIDTH-1:0] q_next_s;
    logic             tc_next_s;
    logic [EW-1:0]    q_ext_s;
    logic [EW-1:0]    din_ext_s;

    assign q_ext_s   = {1'b0, q_r};
    assign din_ext_s = {1'b0, din};

    // Next-state selection: hold when disabled, otherwise apply the selected mode.
    always_comb begin
        q_next_s  = q_r;
        tc_next_s = 1'b0;
        if (!en) begin
            q_next_s  = q_r;
            tc_next_s = 1'b0;
        end else begin
            case (mode_e'(mode))
                MODE_JK: begin
                    // Per bit: 00 hold, 01 clear, 10 set, 11 toggle.
                    q_next_s  = (j & ~q_r) | (~k & q_r);
                    tc_next_s = 1'b0;
                end
                MODE_UP: begin
                    if (q_ext_s < MAX_E) begin
                        // No carry out possible here because q < MODULUS-1.
                        q_next_s  = q_r + WIDTH'(1);
                        tc_next_s = 1'b0;
                    end else begin
                        // Terminal value or out-of-range value both wrap to zero.
                        q_next_s  = {WIDTH{1'b0}};
                        tc_next_s = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (q_ext_s == {EW{1'b0}}) begin
                        q_next_s  = MAX_Q;
                        tc_next_s = 1'b1;
                    end else if (q_ext_s < MOD_E) begin
                        q_next_s  = q_r - WIDTH'(1);
                        tc_next_s = 1'b0;
                    end else begin
                        // Out-of-range value recovers to the top without a pulse.
                        q_next_s  = MAX_Q;
                        tc_next_s = 1'b0;
                    end
                end
                MODE_LOAD: begin
                    if (din_ext_s < MOD_E) begin
                        q_next_s = din;
                    end else begin
                        q_next_s = MAX_Q;
                    end
                    tc_next_s = 1'b0;
                end
                default: begin
                    q_next_s  = q_r;
                    tc_next_s = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset; reset also suppresses any pending tc.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r  <= {WIDTH{1'b0}};
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_next_s;
            tc_r <= tc_next_s;
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign zero = (q_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_jk_mode_counter.sv
// Directed bench for jk_mode_counter: a MODULUS=10 instance (a) and a full-range
// MODULUS=16 instance (b) share all inputs; expectations are hand-computed.
module tb_jk_mode_counter;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] mode;
    logic [3:0] j, k, din;
    logic [3:0] qa, qb;
    logic       tca, tcb, zeroa, zerob;

    int pass_cnt  = 0;
    int total_cnt = 0;

    jk_mode_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .din(din),
        .q(qa), .tc(tca), .zero(zeroa)
    );

    jk_mode_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .din(din),
        .q(qb), .tc(tcb), .zero(zerob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd);
        rst = r; en = e; mode = m; j = jj; k = kk; din = dd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eq, input logic etc);
        chk({tag, "_qa"}, {28'd0, qa}, {28'd0, eq});
        chk({tag, "_tca"}, {31'd0, tca}, {31'd0, etc});
        chk({tag, "_zeroa"}, {31'd0, zeroa}, {31'd0, (eq == 4'd0)});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] eq, input logic etc);
        chk({tag, "_qb"}, {28'd0, qb}, {28'd0, eq});
        chk({tag, "_tcb"}, {31'd0, tcb}, {31'd0, etc});
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("reset", 4'd0, 1'b0);
        chk_b("reset", 4'd0, 1'b0);

        // T1: up-count 12 cycles, a wraps after 9, b simply counts.
        drive(1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk_a("t1_up", 4'(i % 10), (i == 10));
            chk_b("t1_up", 4'(i), 1'b0);
        end

        // T2: reset, then down-count 3 cycles from zero.
        drive(1'b1, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("t2_rst", 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("t2_d1", 4'd9, 1'b1);
        chk_b("t2_d1", 4'd15, 1'b1);
        cyc();
        chk_a("t2_d2", 4'd8, 1'b0);
        chk_b("t2_d2", 4'd14, 1'b0);
        cyc();
        chk_a("t2_d3", 4'd7, 1'b0);
        chk_b("t2_d3", 4'd13, 1'b0);

        // T3: load 0101, then JK patterns.
        drive(1'b0, 1'b1, 2'b11, 4'd0, 4'd0, 4'b0101);
        cyc();
        chk_a("t3_load", 4'b0101, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 4'b1100, 4'b0110, 4'd0);
        cyc();
        chk_a("t3_jk1", 4'b1001, 1'b0);
        chk_b("t3_jk1", 4'b1001, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111, 4'd0);
        cyc();
        chk_a("t3_jk2", 4'b0110, 1'b0);
        chk_b("t3_jk2", 4'b0110, 1'b0);

        // T4: load in range and clamped.
        drive(1'b0, 1'b1, 2'b11, 4'd0, 4'd0, 4'd7);
        cyc();
        chk_a("t4_ld7", 4'd7, 1'b0);
        chk_b("t4_ld7", 4'd7, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 4'd0, 4'd0, 4'd13);
        cyc();
        chk_a("t4_ld13", 4'd9, 1'b0);
        chk_b("t4_ld13", 4'd13, 1'b0);

        // T5: out-of-range q=12 via JK set, then up and down behaviour.
        drive(1'b0, 1'b1, 2'b00, 4'b1100, 4'b0011, 4'd0);
        cyc();
        chk_a("t5_set", 4'd12, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("t5_up", 4'd0, 1'b1);
        chk_b("t5_up", 4'd13, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 4'b1100, 4'b0011, 4'd0);
        cyc();
        chk_a("t5_set2", 4'd12, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("t5_dn", 4'd9, 1'b0);
        chk_b("t5_dn", 4'd11, 1'b0);

        // Full-range boundary: load 15 (b keeps it, a clamps), then up wraps both.
        drive(1'b0, 1'b1, 2'b11, 4'd0, 4'd0, 4'd15);
        cyc();
        chk_a("b_ld15", 4'd9, 1'b0);
        chk_b("b_ld15", 4'd15, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("b_wrap", 4'd0, 1'b1);
        chk_b("b_wrap", 4'd0, 1'b1);
        cyc();
        chk_a("b_up1", 4'd1, 1'b0);
        chk_b("b_up1", 4'd1, 1'b0);

        // Hold with en=0 on a non-zero value, mode still up.
        drive(1'b0, 1'b0, 2'b01, 4'b1111, 4'b1111, 4'd0);
        cyc();
        chk_a("hold1", 4'd1, 1'b0);
        cyc();
        chk_a("hold2", 4'd1, 1'b0);
        chk_b("hold2", 4'd1, 1'b0);

        // T6: reset, count to 9, reset on the wrap edge suppresses tc.
        drive(1'b1, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        for (int i = 1; i <= 9; i++) cyc();
        chk_a("t6_at9", 4'd9, 1'b0);
        drive(1'b1, 1'b1, 2'b01, 4'd0, 4'd0, 4'd0);
        cyc();
        chk_a("t6_rst", 4'd0, 1'b0);
        chk_b("t6_rst", 4'd0, 1'b0);
        drive(1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk_a("t6_hold", 4'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
